// File: rtl/fsm_drv_pkg.sv
// Shared types and protocol constants for the transaction driver and its phase checker.
package fsm_drv_pkg;

    typedef enum logic [3:0] {
        D_IDLE,
        D_START,
        D_HDR,
        D_SEL,
        D_P1,
        D_P2,
        D_P3,
        D_DN,
        D_ERR
    } drv_state_e;

    localparam logic [7:0] HDR_OK   = 8'h01;
    localparam logic [7:0] HDR_BAD  = 8'h00;
    localparam logic [7:0] SEL_CMD  = 8'h0A;
    localparam logic [7:0] P2_SET   = 8'h80;
    localparam logic [7:0] ERR_EXIT = 8'h07;
    localparam logic [7:0] ERR_CODE = 8'hEE;

endpackage

// File: rtl/fsm_drv_checker.sv
// Combinational per-phase check of the consumer response against the value each phase expects.
module fsm_drv_checker
    import fsm_drv_pkg::*;
(
    input  drv_state_e  state,
    input  logic [7:0]  payload,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        mismatch
);

    logic [7:0] p2_data;
    logic [7:0] exp_data;
    logic       chk_data;

    assign p2_data = payload | P2_SET;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        exp_data = 8'h00;
        chk_data = 1'b0;
        case (state)
            D_SEL: begin exp_data = SEL_CMD;               chk_data = 1'b1; end
            D_P1:  begin exp_data = payload + 8'd1;        chk_data = 1'b1; end
            D_P2:  begin exp_data = {p2_data[6:0], 1'b0};  chk_data = 1'b1; end
            D_P3:  begin exp_data = ~payload;              chk_data = 1'b1; end
            D_DN:  begin exp_data = payload;               chk_data = 1'b1; end
            D_ERR: begin exp_data = ERR_CODE;              chk_data = 1'b1; end
            default: ;
        endcase
    end

    // rx_done must be high in D_DN and low in every other active phase.
    always_comb begin
        mismatch = 1'b0;
        if (state != D_IDLE) begin
            mismatch = (rx_done != (state == D_DN)) || (chk_data && (rx_data != exp_data));
        end
    end

endmodule

// File: rtl/fsm_txn_driver.sv
// Transaction driver sequencing a consumer FSM through header/select/payload phases or an abort path.
// Define FSM_DRV_CHECK_EN to build the per-phase response checker that drives rsp_err.
module fsm_txn_driver
    import fsm_drv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_payload,
    input  logic        req_abort,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err
);

    drv_state_e state_q, state_d;
    logic [7:0] pay_q;
    logic       abort_q;
    logic       accept;
    logic       final_phase;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    assign req_ready   = (state_q == D_IDLE);
    assign accept      = req_valid && req_ready;
    assign final_phase = (state_q == D_DN) || (state_q == D_ERR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (req_valid) state_d = D_START;
            D_START: state_d = D_HDR;
            D_HDR:   state_d = abort_q ? D_ERR : D_SEL;
            D_SEL:   state_d = D_P1;
            D_P1:    state_d = D_P2;
            D_P2:    state_d = D_P3;
            D_P3:    state_d = D_DN;
            D_DN:    state_d = D_IDLE;
            D_ERR:   state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == D_START);
        tx_data  = 8'h00;
        case (state_q)
            D_HDR:            tx_data = abort_q ? HDR_BAD : HDR_OK;
            D_SEL:            tx_data = SEL_CMD;
            D_P1, D_P3, D_DN: tx_data = pay_q;
            D_P2:             tx_data = pay_q | P2_SET;
            D_ERR:            tx_data = ERR_EXIT;
            default:          tx_data = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= D_IDLE;
            pay_q       <= 8'h00;
            abort_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= final_phase;
            if (accept) begin
                pay_q   <= req_payload;
                abort_q <= req_abort;
            end
            if (final_phase) rsp_data_q <= rx_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef FSM_DRV_CHECK_EN
    logic mismatch;
    logic err_acc_q;
    logic rsp_err_q;

    fsm_drv_checker u_checker (
        .state    (state_q),
        .payload  (pay_q),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .mismatch (mismatch)
    );

    // err_acc_q tracks the running transaction; rsp_err_q is the published copy that holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                err_acc_q <= 1'b0;
            end else if (mismatch) begin
                err_acc_q <= 1'b1;
            end
            if (final_phase) rsp_err_q <= err_acc_q | mismatch;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_rx_done;
    assign unused_rx_done = rx_done;
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_txn_driver.sv
// Bench for fsm_txn_driver: emulated consumer FSM plus a cycle-count reference model of the driver.
module tb_fsm_txn_driver;

`ifdef FSM_DRV_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_payload;
    logic       req_abort;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fsm_txn_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_payload (req_payload),
        .req_abort   (req_abort),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    // Consumer emulation; corruption mode 1 inverts its P3 answer, mode 2 raises done early in P1.
    int         cur_corrupt = 0;
    logic [2:0] c_step;
    logic       c_abort;
    logic [7:0] c_pay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_step  <= 3'd0;
            c_abort <= 1'b0;
            c_pay   <= 8'h00;
        end else if (tx_start) begin
            c_step <= 3'd1;
        end else if (c_step != 3'd0) begin
            if (c_step == 3'd1) c_abort <= (tx_data == 8'h00);
            if (c_step == 3'd3) c_pay <= tx_data;
            if ((c_step == 3'd2 && c_abort) || c_step == 3'd6) c_step <= 3'd0;
            else c_step <= c_step + 3'd1;
        end
    end

    always_comb begin
        rx_data = 8'h00;
        rx_done = 1'b0;
        case (c_step)
            3'd2: rx_data = c_abort ? 8'hEE : tx_data;
            3'd3: begin
                rx_data = tx_data + 8'd1;
                rx_done = (cur_corrupt == 2);
            end
            3'd4: rx_data = {tx_data[6:0], 1'b0};
            3'd5: rx_data = (cur_corrupt == 1) ? tx_data : ~tx_data;
            3'd6: begin rx_data = c_pay; rx_done = 1'b1; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a transaction is just "k cycles since accept" plus the latched request.
    bit         m_busy = 0;
    int         m_k = 0;
    logic [7:0] m_pay = 8'h00;
    bit         m_abort = 0;
    int         m_corrupt = 0;
    bit         m_pulse = 0;
    logic [7:0] m_rsp_data = 8'h00;
    bit         m_rsp_err = 0;

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_pay = 8'h00; m_abort = 0; m_corrupt = 0;
        m_pulse = 0; m_rsp_data = 8'h00; m_rsp_err = 0;
    endtask

    task automatic check_outputs();
        logic       e_start;
        logic [7:0] e_data;
        e_start = 1'b0;
        e_data  = 8'h00;
        if (m_busy) begin
            if (m_k == 1) e_start = 1'b1;
            else if (m_abort) e_data = (m_k == 2) ? 8'h00 : 8'h07;
            else if (m_k == 2) e_data = 8'h01;
            else if (m_k == 3) e_data = 8'h0A;
            else if (m_k == 5) e_data = m_pay | 8'h80;
            else e_data = m_pay;
        end
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("tx_start",  32'(tx_start),  32'(e_start));
        check("tx_data",   32'(tx_data),   32'(e_data));
        check("rsp_valid", 32'(rsp_valid), 32'(m_pulse));
        check("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
        check("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
    endtask

    // Called at a falling edge: check, drive the next inputs, advance the model over the rising edge.
    task automatic cycle(input logic v, input logic [7:0] p, input logic a, input int cm);
        bit pulse_next;
        check_outputs();
        req_valid   = v;
        req_payload = p;
        req_abort   = a;
        pulse_next  = 0;
        if (m_busy) begin
            m_k++;
            if (m_k == (m_abort ? 4 : 8)) begin
                m_busy     = 0;
                pulse_next = 1;
                m_rsp_data = m_abort ? 8'hEE : m_pay;
                m_rsp_err  = CHECK_ON && (m_corrupt != 0);
            end
        end else if (v) begin
            m_busy      = 1;
            m_k         = 1;
            m_pay       = p;
            m_abort     = a;
            m_corrupt   = a ? 0 : cm;
            cur_corrupt = m_corrupt;
        end
        m_pulse = pulse_next;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_payload = 8'h00;
        req_abort   = 1'b0;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle(2);

        // Normal, payload 35
        cycle(1'b1, 8'h35, 1'b0, 0);
        idle(9);
        // Abort, payload 00
        cycle(1'b1, 8'h00, 1'b1, 0);
        idle(5);
        // Corrupted P3, payload FF
        cycle(1'b1, 8'hFF, 1'b0, 1);
        idle(9);
        // Early rx_done in P1
        cycle(1'b1, 8'h5C, 1'b0, 2);
        idle(9);
        // Back-to-back with req_valid held high: 01 then FF
        cycle(1'b1, 8'h01, 1'b0, 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF, 1'b0, 0);
        idle(10);

        // Reset while in P2 (k == 5)
        cycle(1'b1, 8'h42, 1'b0, 0);
        for (int i = 0; i < 20 && m_k != 5; i++) cycle(1'b0, 8'h00, 1'b0, 0);
        check("reached_p2", 32'(m_k), 32'd5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_tx_start",  32'(tx_start),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_tx_data",   32'(tx_data),   32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle(2);
        cycle(1'b1, 8'h9D, 1'b0, 0);
        idle(9);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       v;
            logic [7:0] p;
            logic       a;
            int         cm;
            v  = ($urandom_range(0, 3) != 0);
            p  = 8'($urandom);
            a  = ($urandom_range(0, 4) == 0);
            cm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            cycle(v, p, a, cm);
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
